// File: rtl/led_pkg.sv
// Shared types and constants for the LED controller: channel modes and
// breathe direction encodings.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_BLINK   = 2'd1,
    MODE_PWM     = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/led_channel.sv
// One LED channel: holds mode/duty/level/direction/phase, advances on the
// shared tick, and produces a registered LED bit by comparing against the
// shared PWM counter. A write in the same cycle as a tick takes precedence.
module led_channel
  import led_pkg::*;
#(
  parameter int DUTY_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [1:0]        wr_mode,
  input  logic [DUTY_W-1:0] wr_duty,
  input  logic              tick,
  input  logic [DUTY_W-1:0] pwm_cnt,
  output logic              led
);

  localparam logic [DUTY_W-1:0] LEVEL_MAX = '1;

  mode_t             mode, mode_nxt;
  logic [DUTY_W-1:0] duty, duty_nxt;
  logic [DUTY_W-1:0] level, level_nxt;
  logic              dir, dir_nxt;
  logic              phase, phase_nxt;
  logic              led_nxt;

  // Next channel state: a write reloads the channel, otherwise a tick steps
  // the blink phase or the breathe triangle (bouncing at 0 and max).
  always_comb begin
    mode_nxt  = mode;
    duty_nxt  = duty;
    level_nxt = level;
    dir_nxt   = dir;
    phase_nxt = phase;
    if (wr) begin
      mode_nxt  = mode_t'(wr_mode);
      duty_nxt  = wr_duty;
      level_nxt = '0;
      dir_nxt   = DIR_UP;
      phase_nxt = 1'b0;
    end else if (tick) begin
      case (mode)
        MODE_BLINK: phase_nxt = ~phase;
        MODE_BREATHE: begin
          if (dir == DIR_UP) begin
            if (level == LEVEL_MAX) begin
              dir_nxt   = DIR_DOWN;
              level_nxt = level - 1'b1;
            end else begin
              level_nxt = level + 1'b1;
            end
          end else begin
            if (level == '0) begin
              dir_nxt   = DIR_UP;
              level_nxt = level + 1'b1;
            end else begin
              level_nxt = level - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // LED compare for the current mode, registered below.
  always_comb begin
    case (mode)
      MODE_BLINK:   led_nxt = phase;
      MODE_PWM:     led_nxt = (pwm_cnt < duty);
      MODE_BREATHE: led_nxt = (pwm_cnt < level);
      default:      led_nxt = 1'b0;
    endcase
  end

  // Channel state and LED register; reset leaves the channel OFF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode  <= MODE_OFF;
      duty  <= '0;
      level <= '0;
      dir   <= DIR_UP;
      phase <= 1'b0;
      led   <= 1'b0;
    end else begin
      mode  <= mode_nxt;
      duty  <= duty_nxt;
      level <= level_nxt;
      dir   <= dir_nxt;
      phase <= phase_nxt;
      led   <= led_nxt;
    end
  end

endmodule

// File: rtl/led_ctrl.sv
// Multi-channel LED controller: shared prescaler (tick) and PWM counter,
// config write decode, and one led_channel per output. CH_W may be widened
// beyond the minimum so out-of-range channel indices can be presented.
module led_ctrl
  import led_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 24,
  parameter int DUTY_W   = 8,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [DUTY_W-1:0]   cfg_duty,
  output logic [CHANNELS-1:0] led,
  output logic                tick
);

  logic              rst_meta;
  logic              rst_sync_n;
  logic [WIDTH-1:0]  presc;
  logic [DUTY_W-1:0] pwm_cnt;
  logic [31:0]       ch_idx;
  logic              ch_ok;
  logic [CHANNELS-1:0] wr_vec;

  // Reset synchroniser: asserts immediately, releases after two clk edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta   <= 1'b0;
      rst_sync_n <= 1'b0;
    end else begin
      rst_meta   <= 1'b1;
      rst_sync_n <= rst_meta;
    end
  end

  // Free-running prescaler and PWM counter; tick marks the prescaler wrap.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      presc   <= '0;
      pwm_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      presc   <= presc + 1'b1;
      pwm_cnt <= pwm_cnt + 1'b1;
      tick    <= &presc;
    end
  end

  assign ch_idx = 32'(cfg_ch);
  assign ch_ok  = (ch_idx < 32'(CHANNELS));

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign wr_vec[i] = cfg_we && ch_ok && (ch_idx == 32'(i));

    led_channel #(
      .DUTY_W(DUTY_W)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_sync_n),
      .wr      (wr_vec[i]),
      .wr_mode (cfg_mode),
      .wr_duty (cfg_duty),
      .tick    (tick),
      .pwm_cnt (pwm_cnt),
      .led     (led[i])
    );
  end

endmodule

// File: tb/tb_led_ctrl.sv
// Directed bench for led_ctrl with WIDTH=4, DUTY_W=4, CHANNELS=4 and a
// 3-bit channel index so out-of-range writes can be driven.
module tb_led_ctrl;
  import led_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       cfg_we;
  logic [2:0] cfg_ch;
  logic [1:0] cfg_mode;
  logic [3:0] cfg_duty;
  logic [3:0] led;
  logic       tick;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0] mode;
    logic [3:0] duty;
    int         exp_high;
  } pwm_vec_t;

  pwm_vec_t vecs[7];

  led_ctrl #(
    .CHANNELS(4),
    .WIDTH(4),
    .DUTY_W(4),
    .CH_W(3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_mode (cfg_mode),
    .cfg_duty (cfg_duty),
    .led      (led),
    .tick     (tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One config write, driven at a falling edge and held for one rising edge.
  task automatic applyStimulus(input logic [2:0] ch, input logic [1:0] mode, input logic [3:0] duty);
    cfg_we   = 1'b1;
    cfg_ch   = ch;
    cfg_mode = mode;
    cfg_duty = duty;
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Steps at least once, until tick is seen high; n = falling edges stepped.
  task automatic waitTick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 100);
  endtask

  task automatic countHigh(input int idx, input int cycles, output int hi);
    hi = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (led[idx]) hi++;
    end
  endtask

  task automatic countAny(input int cycles, output int hi);
    hi = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (led != 4'b0000) hi++;
    end
  endtask

  initial begin
    int n;
    int hi;
    int exp_lvl;

    vecs[0] = '{MODE_PWM, 4'd4,  4};
    vecs[1] = '{MODE_PWM, 4'd0,  0};
    vecs[2] = '{MODE_PWM, 4'd15, 15};
    vecs[3] = '{MODE_PWM, 4'd8,  8};
    vecs[4] = '{MODE_OFF, 4'd9,  0};
    vecs[5] = '{MODE_PWM, 4'd1,  1};
    vecs[6] = '{MODE_PWM, 4'd4,  4};

    rst_n    = 1'b0;
    cfg_we   = 1'b0;
    cfg_ch   = '0;
    cfg_mode = '0;
    cfg_duty = '0;

    // Reset state and first tick after release (2 sync edges + 16 counts).
    step(3);
    checkOutput("reset led", int'(led), 0);
    checkOutput("reset tick", int'(tick), 0);
    rst_n = 1'b1;
    waitTick(n);
    checkOutput("first tick latency", n, 18);
    step(1);
    checkOutput("tick width", int'(tick), 0);
    waitTick(n);
    checkOutput("tick period", n + 1, 16);
    step(1);

    // BLINK on ch0: led follows phase one edge late.
    applyStimulus(3'd0, MODE_BLINK, 4'd0);
    waitTick(n);
    step(1);
    checkOutput("blink ch0 lag", int'(led[0]), 0);
    step(1);
    checkOutput("blink ch0 on", int'(led[0]), 1);
    checkOutput("blink others off", int'(led[3:1]), 0);
    waitTick(n);
    checkOutput("blink half period", n + 2, 16);
    step(2);
    checkOutput("blink ch0 off", int'(led[0]), 0);
    waitTick(n);
    step(2);
    checkOutput("blink ch0 on again", int'(led[0]), 1);

    // PWM / OFF table on ch1: highs per 16-cycle window.
    for (int v = 0; v < 7; v++) begin
      applyStimulus(3'd1, vecs[v].mode, vecs[v].duty);
      step(1);
      countHigh(1, 16, hi);
      checkOutput($sformatf("pwm vec %0d duty %0d", v, vecs[v].duty), hi, vecs[v].exp_high);
    end

    // BREATHE on ch2: level rises 1..15 then falls to 0, one step per tick.
    applyStimulus(3'd2, MODE_BREATHE, 4'd0);
    waitTick(n);
    step(1);
    for (int k = 1; k <= 30; k++) begin
      exp_lvl = (k <= 15) ? k : 30 - k;
      countHigh(2, 16, hi);
      checkOutput($sformatf("breathe tick %0d", k), hi, exp_lvl);
    end

    // Write ch3 BLINK in the tick cycle: that tick must not toggle phase.
    waitTick(n);
    applyStimulus(3'd3, MODE_BLINK, 4'd0);
    countHigh(3, 15, hi);
    checkOutput("collision no advance", hi, 0);
    step(1);
    checkOutput("collision lag", int'(led[3]), 0);
    step(1);
    checkOutput("collision next tick", int'(led[3]), 1);

    // Out-of-range channel write must not alias onto ch1 (PWM duty 4).
    applyStimulus(3'd5, MODE_PWM, 4'd15);
    step(1);
    countHigh(1, 16, hi);
    checkOutput("bounds ch5 ignored", hi, 4);

    // Async reset mid-cycle while LEDs are active.
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (led == 4'b0000 && n < 64);
    checkOutput("led active before reset", int'(led != 4'b0000), 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset led", int'(led), 0);
    checkOutput("async reset tick", int'(tick), 0);
    step(3);
    rst_n = 1'b1;
    countAny(48, hi);
    checkOutput("all off after reset", hi, 0);
    applyStimulus(3'd0, MODE_PWM, 4'd8);
    step(1);
    countHigh(0, 16, hi);
    checkOutput("rewrite after reset", hi, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
